// File: rtl/gpa_fhdo_pkg.sv
// Shared definitions for the GPA-FHDO DAC80504 SPI target emulation.
// Holds the register addresses, the frame constants, the TRIGGER register
// codes and the SPI target state encoding.
package gpa_fhdo_pkg;

    localparam logic [3:0] ADDR_NOP     = 4'h0;
    localparam logic [3:0] ADDR_DEVID   = 4'h1;
    localparam logic [3:0] ADDR_SYNC    = 4'h2;
    localparam logic [3:0] ADDR_TRIGGER = 4'h5;
    localparam logic [3:0] ADDR_BRDCAST = 4'h6;
    localparam logic [3:0] ADDR_DAC0    = 4'h8;
    localparam logic [3:0] ADDR_DAC1    = 4'h9;
    localparam logic [3:0] ADDR_DAC2    = 4'hA;
    localparam logic [3:0] ADDR_DAC3    = 4'hB;

    localparam int         FRAME_BITS    = 24;
    localparam int         CNT_SAT       = 25;
    localparam logic [3:0] SOFT_RST_CODE = 4'b1010;
    localparam int         TRIG_LDAC_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/gpa_fhdo_spi_target_spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, plus a history flop
// used to produce single-cycle rise/fall strobes in the clk domain.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input pin
//   level      : synchronised level
//   rise, fall : one-cycle edge strobes of the synchronised level
// RST_VAL is the idle level of the pin, so that releasing reset with the
// pin idle produces no spurious edge.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            hist <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~hist;
    assign fall  = ~sync & hist;

endmodule

// File: rtl/gpa_fhdo_spi_target.sv
// DAC80504 emulation for the GPA-FHDO board: SPI target end of the
// gpa_fhdo_iface link. All pins are oversampled on clk (>= 4x sclk).
// SPI timing: sclk idles high, sdi is captured on sclk falling edges, sdo
// presents the MSB from the csn falling edge and advances on sclk rising.
// Ports:
//   clk, rst_n                    : system clock, async active-low reset
//   sclk, csn, sdi, ldacn         : asynchronous SPI / load-DAC pins
//   sdo                           : readback data (0 while idle)
//   vout0..vout3                  : active 16-bit DAC codes
//   frame_ok_o, frame_err_o       : one-cycle frame accepted/discarded pulses
// Build option: define GPA_FHDO_SPI_TARGET_BRDCAST_EN to map the BRDCAST
// register (0x6), which writes all four DAC buffers at once.
//
// state  | meaning
// IDLE   | waiting for csn falling edge
// SHIFT  | frame in progress, counting sclk falling edges
// COMMIT | one cycle: apply or discard the captured frame
module gpa_fhdo_spi_target
    import gpa_fhdo_pkg::*;
#(
    parameter logic [15:0] DEVICE_ID = 16'h0214,
    parameter logic [3:0]  SYNC_RST  = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        csn,
    input  logic        sdi,
    input  logic        ldacn,
    output logic        sdo,
    output logic [15:0] vout0,
    output logic [15:0] vout1,
    output logic [15:0] vout2,
    output logic [15:0] vout3,
    output logic        frame_err_o,
    output logic        frame_ok_o
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic csn_lvl, csn_rise, csn_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic ldacn_lvl, ldacn_rise, ldacn_fall;
    logic unused_sync;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_csn (
        .clk(clk), .rst_n(rst_n), .din(csn),
        .level(csn_lvl), .rise(csn_rise), .fall(csn_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .din(sdi),
        .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ldacn (
        .clk(clk), .rst_n(rst_n), .din(ldacn),
        .level(ldacn_lvl), .rise(ldacn_rise), .fall(ldacn_fall));

    assign unused_sync = ^{sclk_lvl, csn_lvl, sdi_rise, sdi_fall, ldacn_lvl, ldacn_rise};

    spi_state_t        state;
    logic [4:0]        bit_cnt;
    logic [23:0]       rx_sr;
    logic [23:0]       tx_sr;
    logic [15:0]       rdbk_q;
    logic [3:0]        sync_q;
    logic [3:0][15:0]  dac_buf;
    logic [3:0][15:0]  vout_q;

    logic              frame_good, wr_en, rd_en;
    logic [3:0]        addr;
    logic [15:0]       data;
    logic [3:0][15:0]  buf_nxt;
    logic [3:0]        sync_nxt;
    logic [3:0]        dac_wr;
    logic              soft_ldac, soft_rst, copy_sync;
    logic [15:0]       rd_data;
`ifdef GPA_FHDO_SPI_TARGET_BRDCAST_EN
    logic [15:0]       brd_q, brd_nxt;
`endif

    assign addr       = rx_sr[19:16];
    assign data       = rx_sr[15:0];
    assign frame_good = (state == ST_COMMIT) && (bit_cnt == 5'(FRAME_BITS));
    assign wr_en      = frame_good && !rx_sr[23];
    assign rd_en      = frame_good && rx_sr[23];
    assign copy_sync  = ldacn_fall || soft_ldac;

    // Next buffer values are computed first so that an LDAC copy landing
    // on the same cycle as a DAC write picks up the freshly written code.
    always_comb begin
        buf_nxt   = dac_buf;
        sync_nxt  = sync_q;
        dac_wr    = 4'b0000;
        soft_ldac = 1'b0;
        soft_rst  = 1'b0;
`ifdef GPA_FHDO_SPI_TARGET_BRDCAST_EN
        brd_nxt   = brd_q;
`endif
        if (wr_en) begin
            case (addr)
                ADDR_SYNC: sync_nxt = data[3:0];
                ADDR_TRIGGER: begin
                    soft_ldac = data[TRIG_LDAC_BIT];
                    soft_rst  = (data[3:0] == SOFT_RST_CODE);
                end
`ifdef GPA_FHDO_SPI_TARGET_BRDCAST_EN
                ADDR_BRDCAST: begin
                    buf_nxt = {4{data}};
                    dac_wr  = 4'b1111;
                    brd_nxt = data;
                end
`endif
                ADDR_DAC0, ADDR_DAC1, ADDR_DAC2, ADDR_DAC3: begin
                    buf_nxt[addr[1:0]] = data;
                    dac_wr[addr[1:0]]  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        case (addr)
            ADDR_DEVID: rd_data = DEVICE_ID;
            ADDR_SYNC:  rd_data = {12'h000, sync_q};
`ifdef GPA_FHDO_SPI_TARGET_BRDCAST_EN
            ADDR_BRDCAST: rd_data = brd_q;
`endif
            ADDR_DAC0, ADDR_DAC1, ADDR_DAC2, ADDR_DAC3: rd_data = dac_buf[addr[1:0]];
            default: rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            rdbk_q      <= '0;
            sync_q      <= SYNC_RST;
            dac_buf     <= '0;
            vout_q      <= '0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef GPA_FHDO_SPI_TARGET_BRDCAST_EN
            brd_q       <= '0;
`endif
        end else begin
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (csn_fall) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        tx_sr   <= {8'h00, rdbk_q};
                    end
                end
                ST_SHIFT: begin
                    if (csn_rise) begin
                        state <= ST_COMMIT;
                        tx_sr <= '0;
                    end else begin
                        if (sclk_fall) begin
                            rx_sr <= {rx_sr[22:0], sdi_lvl};
                            if (bit_cnt != 5'(CNT_SAT))
                                bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (sclk_rise)
                            tx_sr <= {tx_sr[22:0], 1'b0};
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (frame_good)
                        frame_ok_o <= 1'b1;
                    else
                        frame_err_o <= 1'b1;
                    if (rd_en)
                        rdbk_q <= rd_data;
                end
                default: state <= ST_IDLE;
            endcase

            dac_buf <= buf_nxt;
            sync_q  <= sync_nxt;
`ifdef GPA_FHDO_SPI_TARGET_BRDCAST_EN
            brd_q   <= brd_nxt;
`endif
            for (int i = 0; i < 4; i++) begin
                if (dac_wr[i] && !sync_q[i])
                    vout_q[i] <= buf_nxt[i];
                else if (copy_sync && sync_q[i])
                    vout_q[i] <= buf_nxt[i];
            end

            if (soft_rst) begin
                dac_buf <= '0;
                vout_q  <= '0;
                sync_q  <= SYNC_RST;
                rdbk_q  <= '0;
`ifdef GPA_FHDO_SPI_TARGET_BRDCAST_EN
                brd_q   <= '0;
`endif
            end
        end
    end

    assign sdo   = tx_sr[23];
    assign vout0 = vout_q[0];
    assign vout1 = vout_q[1];
    assign vout2 = vout_q[2];
    assign vout3 = vout_q[3];

endmodule
